// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg
// Shared constants, queue entry type and width helper for the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int PC_INCR = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic int fetch_clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// In-order circular FIFO of fetched instructions with flush and keep-second.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push,
    input  entry_t                          push_entry,
    input  logic                            pop,
    input  logic                            flush,
    input  logic                            keep_second,
    output logic [fetch_clog2(DEPTH+1)-1:0] count,
    output entry_t                          head
);

    localparam int PTR_W = fetch_clog2(DEPTH);
    localparam int CNT_W = fetch_clog2(DEPTH + 1);

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd;
    logic [PTR_W-1:0]   r_wr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_wr_idx;

    // A push that coincides with a flush becomes the sole entry at slot 0.
    assign w_wr_idx = flush ? '0 : r_wr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= push ? PTR_W'(1) : '0;
            r_count <= push ? CNT_W'(1) : '0;
        end else if (keep_second) begin
            r_rd    <= r_rd + PTR_W'(1);
            r_wr    <= r_rd + PTR_W'(2);
            r_count <= CNT_W'(1);
        end else begin
            if (push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_entry;
        end
    end

    assign head  = r_mem[r_rd];
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// fetch_prefetch_unit
// Credit-limited instruction prefetcher with redirect flush and IF/ID handshake.
// Optional: FETCH_DELAY_SLOT_EN preserves the MIPS branch delay slot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            redirect_valid,
    input  logic [ADDR_WIDTH-1:0]           redirect_pc,
    output logic                            mem_req_valid,
    output logic [ADDR_WIDTH-1:0]           mem_req_addr,
    input  logic                            mem_req_ready,
    input  logic                            mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]           mem_resp_data,
    output logic                            id_valid,
    input  logic                            id_ready,
    output logic [DATA_WIDTH-1:0]           id_instruction,
    output logic [ADDR_WIDTH-1:0]           id_pc,
    output logic [ADDR_WIDTH-1:0]           id_pc_add_4,
    output logic [fetch_clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = fetch_clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] c_pc_incr    = ADDR_WIDTH'(PC_INCR);
    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
    localparam logic [CNT_W:0]        c_depth      = (CNT_W+1)'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    logic [ADDR_WIDTH-1:0] r_fetch_pc, r_resp_pc, w_fetch_pc_nxt, w_resp_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [CNT_W-1:0]      r_inflight, r_discard, w_inflight_nxt, w_discard_nxt;
    logic [CNT_W-1:0]      w_count, w_resp_cnt;
    logic [CNT_W:0]        w_credit_used;
    logic                  w_req_fire, w_pop, w_redirect, w_resp_live;
    logic                  w_q_push, w_q_flush, w_q_keep;
    entry_t                w_head, w_push_entry;

`ifdef FETCH_DELAY_SLOT_EN
    logic                  r_fetch_hold, r_resp_hold, w_fetch_hold_nxt, w_resp_hold_nxt;
    logic [ADDR_WIDTH-1:0] r_slot_target, w_slot_target_nxt;
`endif

    assign w_target      = redirect_pc & c_align_mask;
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_count};
    assign mem_req_valid = !reset && !redirect_valid && (w_credit_used < c_depth);
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;
    assign id_valid      = (w_count != '0);
    assign w_pop         = id_valid && id_ready;
    assign w_resp_live   = mem_resp_valid && (r_discard == '0);
    assign w_resp_cnt    = CNT_W'(mem_resp_valid);
    assign w_push_entry  = entry_t'({mem_resp_data, r_resp_pc});

    // Every response retires one outstanding fetch, whether kept or dropped.
    assign w_inflight_nxt = r_inflight + CNT_W'(w_req_fire) - w_resp_cnt;

`ifdef FETCH_DELAY_SLOT_EN
    assign w_redirect = redirect_valid && w_pop;
`else
    assign w_redirect = redirect_valid;
`endif

    always_comb begin
        w_q_push       = 1'b0;
        w_q_flush      = 1'b0;
        w_q_keep       = 1'b0;
        w_fetch_pc_nxt = r_fetch_pc;
        w_resp_pc_nxt  = r_resp_pc;
        w_discard_nxt  = r_discard;
`ifdef FETCH_DELAY_SLOT_EN
        w_fetch_hold_nxt  = r_fetch_hold;
        w_resp_hold_nxt   = r_resp_hold;
        w_slot_target_nxt = r_slot_target;
`endif
        if (w_redirect) begin
            // All outstanding fetches are stale; inflight already covers pending discards.
`ifdef FETCH_DELAY_SLOT_EN
            w_fetch_hold_nxt  = 1'b0;
            w_resp_hold_nxt   = 1'b0;
            w_slot_target_nxt = w_target;
            w_discard_nxt     = r_inflight - w_resp_cnt;
            if (w_count > CNT_W'(1)) begin
                w_q_keep       = 1'b1;
                w_fetch_pc_nxt = w_target;
                w_resp_pc_nxt  = w_target;
            end else if (w_resp_live) begin
                w_q_flush      = 1'b1;
                w_q_push       = 1'b1;
                w_fetch_pc_nxt = w_target;
                w_resp_pc_nxt  = w_target;
            end else if (r_inflight != r_discard) begin
                w_q_flush       = 1'b1;
                w_fetch_pc_nxt  = w_target;
                w_resp_hold_nxt = 1'b1;
                w_discard_nxt   = r_inflight - w_resp_cnt - CNT_W'(1);
            end else begin
                w_q_flush        = 1'b1;
                w_fetch_hold_nxt = 1'b1;
                w_resp_hold_nxt  = 1'b1;
            end
`else
            w_q_flush      = 1'b1;
            w_fetch_pc_nxt = w_target;
            w_resp_pc_nxt  = w_target;
            w_discard_nxt  = r_inflight - w_resp_cnt;
`endif
        end else begin
            w_q_push = w_resp_live;
            if (w_req_fire) begin
                w_fetch_pc_nxt = r_fetch_pc + c_pc_incr;
`ifdef FETCH_DELAY_SLOT_EN
                if (r_fetch_hold) begin
                    w_fetch_pc_nxt   = r_slot_target;
                    w_fetch_hold_nxt = 1'b0;
                end
`endif
            end
            if (w_resp_live) begin
                w_resp_pc_nxt = r_resp_pc + c_pc_incr;
`ifdef FETCH_DELAY_SLOT_EN
                if (r_resp_hold) begin
                    w_resp_pc_nxt   = r_slot_target;
                    w_resp_hold_nxt = 1'b0;
                end
`endif
            end
            if (mem_resp_valid && (r_discard != '0)) begin
                w_discard_nxt = r_discard - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_resp_pc  <= w_resp_pc_nxt;
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_hold  <= 1'b0;
            r_resp_hold   <= 1'b0;
            r_slot_target <= RESET_PC;
        end else begin
            r_fetch_hold  <= w_fetch_hold_nxt;
            r_resp_hold   <= w_resp_hold_nxt;
            r_slot_target <= w_slot_target_nxt;
        end
    end
`endif

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clock       (clock),
        .reset       (reset),
        .push        (w_q_push),
        .push_entry  (w_push_entry),
        .pop         (w_pop),
        .flush       (w_q_flush),
        .keep_second (w_q_keep),
        .count       (w_count),
        .head        (w_head)
    );

    assign id_instruction = w_head.instr;
    assign id_pc          = w_head.pc;
    assign id_pc_add_4    = w_head.pc + c_pc_incr;
    assign occupancy      = w_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
// ============================================================================
// tb_fetch_prefetch_unit
// Random and directed stimulus against a transaction-level fetch model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          mem_req_valid;
    logic [31:0]   mem_req_addr;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [31:0]   mem_resp_data = 32'h0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [31:0]   id_instruction;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc_add_4;
    logic [CW-1:0] occupancy;

    always #5 clock = ~clock;

    fetch_prefetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_add_4    (id_pc_add_4),
        .occupancy      (occupancy)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend[$];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, lat = 1, fires = 0, pops = 0, queued = 0;
    int          ready_mode = 1, idr_mode = 1;
    bit          redir_now = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    logic [31:0] exp_req_addr = RST_PC, exp_id_pc = RST_PC;
    logic [31:0] obs_addr = 32'h0, first_pop_pc = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_1234;
    endfunction

    function automatic bit pick(input int mode);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return (mode == 1);
    endfunction

    // One clock of environment + model: memory returns in order after lat cycles,
    // fetched PCs advance by 4, a redirect restarts both streams and stales all outstanding.
    task automatic tick;
        pend_t cur;
        bit    resp_now;
        bit    exp_rv;
        resp_now = 1'b0;
        cur = '{due: 0, addr: 32'h0, stale: 1'b0};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            cur = pend.pop_front();
            resp_now = 1'b1;
        end
        mem_resp_valid = resp_now;
        mem_resp_data  = resp_now ? instr_of(cur.addr) : 32'h0;
        mem_req_ready  = pick(ready_mode);
        id_ready       = pick(idr_mode);
        redirect_valid = redir_now;
        redirect_pc    = redir_tgt;
        #4;
        exp_rv = !redir_now && ((pend.size() + int'(resp_now) + queued) < DEPTH);
        n_total++;
        if (mem_req_valid !== exp_rv) $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, exp_rv);
        else n_pass++;
        n_total++;
        if (id_valid !== (queued > 0)) $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, queued > 0);
        else n_pass++;
        n_total++;
        if (occupancy !== CW'(queued)) $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy, queued);
        else n_pass++;
        if (mem_req_valid === 1'b1) obs_addr = mem_req_addr;
        if (mem_req_valid === 1'b1 && mem_req_ready) begin
            n_total++;
            if (mem_req_addr !== exp_req_addr) $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, exp_req_addr);
            else n_pass++;
            pend.push_back('{due: cyc + lat, addr: mem_req_addr, stale: 1'b0});
            exp_req_addr = exp_req_addr + 32'd4;
            fires++;
        end
        if (redir_now) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            queued       = 0;
            exp_req_addr = redir_tgt & ~32'h3;
            exp_id_pc    = redir_tgt & ~32'h3;
        end else begin
            if (id_valid === 1'b1 && id_ready) begin
                n_total++;
                if (id_pc !== exp_id_pc) $display("FAIL id_pc cyc=%0d got=%h exp=%h", cyc, id_pc, exp_id_pc);
                else n_pass++;
                n_total++;
                if (id_instruction !== instr_of(exp_id_pc))
                    $display("FAIL id_instr cyc=%0d got=%h exp=%h", cyc, id_instruction, instr_of(exp_id_pc));
                else n_pass++;
                n_total++;
                if (id_pc_add_4 !== exp_id_pc + 32'd4)
                    $display("FAIL id_pc_add_4 cyc=%0d got=%h exp=%h", cyc, id_pc_add_4, exp_id_pc + 32'd4);
                else n_pass++;
                if (pops == 0) first_pop_pc = id_pc;
                pops++;
                exp_id_pc = exp_id_pc + 32'd4;
                if (queued > 0) queued--;
            end
            if (resp_now && !cur.stale) queued++;
        end
        redir_now = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic apply_reset;
        reset          = 1'b1;
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        #2;
        n_total++;
        if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid);
        else n_pass++;
        n_total++;
        if (occupancy !== '0) $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
        else n_pass++;
        n_total++;
        if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid);
        else n_pass++;
        pend.delete();
        queued       = 0;
        exp_req_addr = RST_PC;
        exp_id_pc    = RST_PC;
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        lat = 1; ready_mode = 1; idr_mode = 1; fires = 0;
        tick();
        n_total++;
        if (fires !== 1 || obs_addr !== RST_PC) $display("FAIL first_fetch fires=%0d addr=%h exp=1/%h", fires, obs_addr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_stream;
        apply_reset();
        lat = 1; ready_mode = 1; idr_mode = 1; pops = 0;
        repeat (12) tick();
        n_total++;
        if (pops !== 10 || first_pop_pc !== 32'h0) $display("FAIL stream pops=%0d first=%h exp=10/0", pops, first_pop_pc);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        apply_reset();
        lat = 1; ready_mode = 1; idr_mode = 0; fires = 0;
        repeat (10) tick();
        n_total++;
        if (fires !== DEPTH) $display("FAIL stall_fires got=%0d exp=%0d", fires, DEPTH);
        else n_pass++;
        n_total++;
        if (occupancy !== CW'(DEPTH)) $display("FAIL stall_occupancy got=%0d exp=%0d", occupancy, DEPTH);
        else n_pass++;
        idr_mode = 1; pops = 0;
        repeat (8) tick();
        n_total++;
        if (pops < DEPTH || first_pop_pc !== 32'h0) $display("FAIL drain pops=%0d first=%h exp>=4/0", pops, first_pop_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_inflight;
        apply_reset();
        lat = 3; ready_mode = 1; idr_mode = 1;
        repeat (3) tick();
        redir_now = 1'b1; redir_tgt = 32'h100; pops = 0;
        repeat (12) tick();
        n_total++;
        if (pops == 0 || first_pop_pc !== 32'h100) $display("FAIL redirect_first pops=%0d got=%h exp=00000100", pops, first_pop_pc);
        else n_pass++;
    endtask

    task automatic test_req_stall;
        apply_reset();
        lat = 1; ready_mode = 1; idr_mode = 1;
        repeat (2) tick();
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (obs_addr !== 32'h8) $display("FAIL hold_addr step=%0d got=%h exp=00000008", i, obs_addr);
            else n_pass++;
        end
        redir_now = 1'b1; redir_tgt = 32'h200;
        tick();
        ready_mode = 1;
        tick();
        n_total++;
        if (obs_addr !== 32'h200) $display("FAIL stall_redirect_addr got=%h exp=00000200", obs_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        lat = 2; ready_mode = 1; idr_mode = 0;
        repeat (5) tick();
        apply_reset();
        idr_mode = 1;
        tick();
        n_total++;
        if (obs_addr !== RST_PC) $display("FAIL restart_addr got=%h exp=%h", obs_addr, RST_PC);
        else n_pass++;
        repeat (6) tick();
    endtask

    task automatic test_wrap;
        lat = 1; ready_mode = 1; idr_mode = 1;
        redir_now = 1'b1; redir_tgt = 32'hFFFF_FFF6; pops = 0;
        repeat (12) tick();
        n_total++;
        if (pops < 6 || first_pop_pc !== 32'hFFFF_FFF4) $display("FAIL wrap pops=%0d first=%h exp>=6/fffffff4", pops, first_pop_pc);
        else n_pass++;
    endtask

    task automatic test_random;
        ready_mode = 2; idr_mode = 2; pops = 0;
        for (int blk = 0; blk < 6; blk++) begin
            lat = $urandom_range(1, 3);
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 15) == 0) begin
                    redir_now = 1'b1;
                    redir_tgt = $urandom;
                end
                tick();
            end
        end
        ready_mode = 1; idr_mode = 1;
        repeat (20) tick();
        n_total++;
        if (pops == 0) $display("FAIL random_progress pops=%0d exp>0", pops);
        else n_pass++;
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_req_stall();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
